// File: rtl/inst_loader_pkg.sv
// Shared constants and state encoding for the instruction-memory loader.
// The CHECK state is present only when INST_LOADER_CHECKSUM_EN is defined.
package inst_loader_pkg;

  localparam int IMEM_WORDS     = 32;
  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int ADDR_LSB       = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RECV  = 3'd1,
    ST_WRITE = 3'd2,
`ifdef INST_LOADER_CHECKSUM_EN
    ST_CHECK = 3'd4,
`endif
    ST_FIN   = 3'd3
  } state_e;

endpackage

// File: rtl/inst_loader_assembler.sv
// Big-endian byte-to-word shift register with a 2-bit byte counter.
// word presents the completed word combined with the byte currently being shifted in.
module byte_assembler
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic              word_full,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    if (clear) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (shift_en) begin
      shreg_d = {shreg_q[WORD_W-9:0], byte_in};
      cnt_d   = cnt_q + 2'd1;
    end
  end

  // Asserted while three bytes are held: the next accepted byte completes the word.
  assign word_full = (cnt_q == 2'(BYTES_PER_WORD - 1));
  assign word      = {shreg_q[WORD_W-9:0], byte_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg_q <= '0;
      cnt_q   <= '0;
    end else begin
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/inst_loader.sv
// Instruction RAM writer: assembles a byte stream into words and holds the CPU during a load.
// Optional trailing XOR checksum byte is enabled by defining INST_LOADER_CHECKSUM_EN.
module inst_loader
  import inst_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [5:0]        load_len,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              wr_en,
  output logic [31:0]       wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [5:0]        len_q, len_d;
  logic [4:0]        word_idx_q, word_idx_d;
  logic [31:0]       wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0] wr_data_q, wr_data_d;
  logic              err_q, err_d;
  logic [7:0]        xor_q, xor_d;
  logic              asm_clear, asm_shift, asm_full;
  logic [WORD_W-1:0] asm_word;
  logic              len_legal, last_word;

  byte_assembler u_asm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (asm_clear),
    .shift_en (asm_shift),
    .byte_in  (byte_data),
    .word_full(asm_full),
    .word     (asm_word)
  );

  assign len_legal = (load_len != 6'd0) && (load_len <= 6'(IMEM_WORDS));
  assign last_word = ({1'b0, word_idx_q} == (len_q - 6'd1));

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    xor_d      = xor_q;
    err_d      = 1'b0;
    asm_clear  = 1'b0;
    asm_shift  = 1'b0;
    byte_ready = 1'b0;
    wr_en      = 1'b0;
    done       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len_legal) begin
            state_d    = ST_RECV;
            len_d      = load_len;
            word_idx_d = '0;
            xor_d      = '0;
            asm_clear  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RECV: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          asm_shift = 1'b1;
          xor_d     = xor_q ^ byte_data;
          if (asm_full) begin
            state_d   = ST_WRITE;
            wr_addr_d = 32'(word_idx_q) << ADDR_LSB;
            wr_data_d = asm_word;
          end
        end
      end
      ST_WRITE: begin
        wr_en      = 1'b1;
        word_idx_d = word_idx_q + 5'd1;
        asm_clear  = 1'b1;
`ifdef INST_LOADER_CHECKSUM_EN
        state_d    = last_word ? ST_CHECK : ST_RECV;
`else
        state_d    = last_word ? ST_FIN : ST_RECV;
`endif
      end
`ifdef INST_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        byte_ready = 1'b1;
        if (byte_valid) begin
          state_d = ST_FIN;
          err_d   = (byte_data != xor_q);
        end
      end
`endif
      ST_FIN: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over everything, including a write or completion in the same cycle.
    if (abort && (state_q != ST_IDLE)) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      word_idx_d = word_idx_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      xor_d      = xor_q;
      asm_clear  = 1'b1;
      asm_shift  = 1'b0;
      byte_ready = 1'b0;
      wr_en      = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      word_idx_q <= '0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      xor_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      xor_q      <= xor_d;
      err_q      <= err_d;
    end
  end

  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign cpu_hold = busy;
  assign err      = err_q;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader: reset, loads, stalls, illegal lengths, abort.
module tb_inst_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  load_len = '0;
  logic        abort = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = '0;
  logic        byte_ready, wr_en, busy, cpu_hold, done, err;
  logic [31:0] wr_addr, wr_data;

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          wr_cnt, done_cnt, err_cnt, br_viol;
  int          done_cyc, err_cyc;
  int          wr_cyc [0:63];
  logic [31:0] wr_addr_log [0:63];
  logic [31:0] wr_data_log [0:63];
  logic [7:0]  stim [0:127];

  inst_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .load_len  (load_len),
    .abort     (abort),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .byte_ready(byte_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .cpu_hold  (cpu_hold),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event log sampled on the falling edge.
  always @(negedge clk) begin
    if (wr_en) begin
      if (wr_cnt < 64) begin
        wr_addr_log[wr_cnt] = wr_addr;
        wr_data_log[wr_cnt] = wr_data;
        wr_cyc[wr_cnt]      = cyc;
      end
      wr_cnt = wr_cnt + 1;
      if (byte_ready) br_viol = br_viol + 1;
    end
    if (done) begin
      done_cnt = done_cnt + 1;
      done_cyc = cyc;
    end
    if (err) begin
      err_cnt = err_cnt + 1;
      err_cyc = cyc;
    end
  end

  task automatic clear_log();
    wr_cnt = 0; done_cnt = 0; err_cnt = 0; br_viol = 0;
    done_cyc = -1; err_cyc = -1;
  endtask

  task automatic do_start(input logic [5:0] n);
    start = 1'b1;
    load_len = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    bit acc = 1'b0;
    repeat (stall) begin @(posedge clk); #1; end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 50 && !acc; i++) begin
      @(negedge clk);
      acc = byte_ready;
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    total++;
    if (!acc) begin
      bad++;
      $display("FAIL handshake_timeout: byte %h got no byte_ready within 50 cycles", b);
    end
  endtask

  task automatic run_load(input int n, input int stall);
    logic [7:0] x = 8'h00;
    do_start(6'(n));
    for (int i = 0; i < n * 4; i++) begin
      send_byte(stim[i], stall);
      x = x ^ stim[i];
    end
`ifdef INST_LOADER_CHECKSUM_EN
    send_byte(x, 0);
`endif
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic load_two_word_stim();
    stim[0] = 8'h3c; stim[1] = 8'h01; stim[2] = 8'h10; stim[3] = 8'h10;
    stim[4] = 8'h3c; stim[5] = 8'h02; stim[6] = 8'h01; stim[7] = 8'h01;
  endtask

  task automatic check_two_word(input string tag);
    total++; if (wr_cnt !== 2) begin bad++; $display("FAIL %s_wr_count: got %0d want 2", tag, wr_cnt); end
    total++; if (wr_addr_log[0] !== 32'h0) begin bad++; $display("FAIL %s_addr0: got %h want 00000000", tag, wr_addr_log[0]); end
    total++; if (wr_data_log[0] !== 32'h3c011010) begin bad++; $display("FAIL %s_data0: got %h want 3c011010", tag, wr_data_log[0]); end
    total++; if (wr_addr_log[1] !== 32'h4) begin bad++; $display("FAIL %s_addr1: got %h want 00000004", tag, wr_addr_log[1]); end
    total++; if (wr_data_log[1] !== 32'h3c020101) begin bad++; $display("FAIL %s_data1: got %h want 3c020101", tag, wr_data_log[1]); end
    total++; if (done_cnt !== 1) begin bad++; $display("FAIL %s_done_count: got %0d want 1", tag, done_cnt); end
    total++; if (err_cnt !== 0) begin bad++; $display("FAIL %s_err_count: got %0d want 0", tag, err_cnt); end
    total++; if (br_viol !== 0) begin bad++; $display("FAIL %s_ready_in_write: got %0d want 0", tag, br_viol); end
`ifndef INST_LOADER_CHECKSUM_EN
    total++; if (done_cyc !== wr_cyc[1] + 1) begin bad++; $display("FAIL %s_done_timing: got cycle %0d want %0d", tag, done_cyc, wr_cyc[1] + 1); end
`endif
    total++; if ({busy, cpu_hold} !== 2'b00) begin bad++; $display("FAIL %s_busy_after: got %b want 00", tag, {busy, cpu_hold}); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom); load_len = 6'($urandom); abort = 1'($urandom);
      byte_valid = 1'($urandom); byte_data = 8'($urandom);
      @(negedge clk);
      total++;
      if ({byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err} !== 70'd0) begin
        bad++;
        $display("FAIL reset_outputs: got %h want 0", {byte_ready, wr_en, wr_addr, wr_data, busy, cpu_hold, done, err});
      end
    end
    start = 0; load_len = 0; abort = 0; byte_valid = 0; byte_data = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if ({byte_ready, busy, cpu_hold, done, err, wr_en} !== 6'b0) begin
      bad++;
      $display("FAIL reset_release: got %b want 000000", {byte_ready, busy, cpu_hold, done, err, wr_en});
    end
    @(posedge clk); #1;
    $display("test_reset: checks so far=%0d bad=%0d", total, bad);
  endtask

  task automatic test_two_word();
    load_two_word_stim();
    clear_log();
    run_load(2, 0);
    check_two_word("two_word");
    $display("test_two_word: writes=%0d done=%0d", wr_cnt, done_cnt);
  endtask

  task automatic test_stalled();
    load_two_word_stim();
    clear_log();
    run_load(2, 3);
    check_two_word("stalled");
    $display("test_stalled: writes=%0d done=%0d", wr_cnt, done_cnt);
  endtask

  task automatic test_illegal_len();
    logic [5:0] lens [0:1];
    lens[0] = 6'd0; lens[1] = 6'd33;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      do_start(lens[k]);
      @(negedge clk);
      total++;
      if ({err, busy} !== 2'b10) begin bad++; $display("FAIL illegal_len_%0d_err_busy: got %b want 10", lens[k], {err, busy}); end
      repeat (3) begin @(posedge clk); #1; end
      total++;
      if (err_cnt !== 1 || wr_cnt !== 0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL illegal_len_%0d_counts: got err=%0d wr=%0d busy=%b want err=1 wr=0 busy=0", lens[k], err_cnt, wr_cnt, busy);
      end
      $display("test_illegal_len: len=%0d err pulses=%0d", lens[k], err_cnt);
    end
  endtask

  task automatic test_full_load();
    int mism = 0;
    for (int w = 0; w < 32; w++) begin
      stim[4*w]   = 8'(w);
      stim[4*w+1] = 8'hA5;
      stim[4*w+2] = 8'h5A;
      stim[4*w+3] = 8'(w) ^ 8'hFF;
    end
    clear_log();
    run_load(32, 0);
    total++; if (wr_cnt !== 32) begin bad++; $display("FAIL full_wr_count: got %0d want 32", wr_cnt); end
    total++; if (wr_addr_log[31] !== 32'h0000007C) begin bad++; $display("FAIL full_last_addr: got %h want 0000007c", wr_addr_log[31]); end
    total++; if (wr_data_log[31] !== 32'h1FA55AE0) begin bad++; $display("FAIL full_last_data: got %h want 1fa55ae0", wr_data_log[31]); end
    for (int w = 0; w < 32; w++)
      if (wr_addr_log[w] !== 32'(w * 4) || wr_data_log[w] !== {8'(w), 8'hA5, 8'h5A, 8'(w) ^ 8'hFF}) mism++;
    total++; if (mism !== 0) begin bad++; $display("FAIL full_all_words: got %0d wrong words want 0", mism); end
    total++; if (done_cnt !== 1 || err_cnt !== 0) begin bad++; $display("FAIL full_done: got done=%0d err=%0d want done=1 err=0", done_cnt, err_cnt); end
    $display("test_full_load: writes=%0d last_addr=%h", wr_cnt, wr_addr_log[31]);
  endtask

  task automatic test_abort();
    for (int i = 0; i < 12; i++) stim[i] = 8'h10 + 8'(i);
    clear_log();
    do_start(6'd3);
    for (int i = 0; i < 6; i++) send_byte(stim[i], 0);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    total++;
    if ({err, busy, cpu_hold, done} !== 4'b1000) begin bad++; $display("FAIL abort_next_cycle: got %b want 1000", {err, busy, cpu_hold, done}); end
    repeat (6) begin @(posedge clk); #1; end
    total++; if (wr_cnt !== 1) begin bad++; $display("FAIL abort_wr_count: got %0d want 1", wr_cnt); end
    total++; if (wr_data_log[0] !== 32'h10111213) begin bad++; $display("FAIL abort_word0: got %h want 10111213", wr_data_log[0]); end
    total++; if (done_cnt !== 0 || err_cnt !== 1) begin bad++; $display("FAIL abort_pulses: got done=%0d err=%0d want done=0 err=1", done_cnt, err_cnt); end
    $display("test_abort: writes=%0d err pulses=%0d", wr_cnt, err_cnt);
    load_two_word_stim();
    clear_log();
    run_load(2, 0);
    check_two_word("after_abort");
    $display("test_abort: follow-up load writes=%0d done=%0d", wr_cnt, done_cnt);
  endtask

`ifdef INST_LOADER_CHECKSUM_EN
  task automatic test_checksum();
    logic [7:0] sums [0:1];
    sums[0] = 8'h1a; sums[1] = 8'h1b;
    for (int k = 0; k < 2; k++) begin
      clear_log();
      do_start(6'd1);
      send_byte(8'h00, 0); send_byte(8'h22, 0); send_byte(8'h18, 0); send_byte(8'h20, 0);
      send_byte(sums[k], 0);
      repeat (3) begin @(posedge clk); #1; end
      total++; if (wr_cnt !== 1 || wr_data_log[0] !== 32'h00221820) begin bad++; $display("FAIL checksum_write_%0d: got cnt=%0d data=%h want 1/00221820", k, wr_cnt, wr_data_log[0]); end
      total++; if (done_cnt !== 1) begin bad++; $display("FAIL checksum_done_%0d: got %0d want 1", k, done_cnt); end
      total++; if (err_cnt !== k) begin bad++; $display("FAIL checksum_err_%0d: got %0d want %0d", k, err_cnt, k); end
      if (k == 1) begin
        total++; if (err_cyc !== done_cyc) begin bad++; $display("FAIL checksum_err_with_done: got err cycle %0d want %0d", err_cyc, done_cyc); end
      end
      $display("test_checksum: sum=%h done=%0d err=%0d", sums[k], done_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    clear_log();
    test_reset();
    test_two_word();
    test_stalled();
    test_illegal_len();
    test_full_load();
    test_abort();
`ifdef INST_LOADER_CHECKSUM_EN
    test_checksum();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, limit 2000000 reached");
    $fatal(1);
  end

endmodule
